// File: rtl/sfrm_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : sfrm_tx_sched
// Purpose  : Serial-frame transmit scheduler. Arbitrates N_REQ word
//            requesters onto one serial link (bit clock, frame sync, data)
//            and shifts each accepted word out MSB first, with frame sync
//            on the first bit and an idle gap after every word.
// Options  : SFRM_TX_PRIO_EN defined   -> fixed priority (lowest index wins)
//            SFRM_TX_PRIO_EN undefined -> round-robin arbitration
// Revision : 1.0 - initial release
// ============================================================================
module sfrm_tx_sched #(
  parameter int N_REQ    = 4,
  parameter int WORD_W   = 16,
  parameter int CLK_DIV  = 2,
  parameter int GAP_BITS = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_vld,
  input  logic [N_REQ*WORD_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_req_rdy,
  output logic                      o_sclk,
  output logic                      o_fs,
  output logic                      o_sd,
  output logic                      o_busy,
  output logic [$clog2(N_REQ)-1:0]  o_src
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int HC_W  = $clog2(CLK_DIV) + 1;
  localparam int GC_W  = $clog2(2 * GAP_BITS) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [HC_W-1:0]      hcnt;
  logic [GC_W-1:0]      gcnt;
  logic [IDX_W-1:0]     idx;
  logic [WORD_W-1:0]    shift;
  logic [SRC_W-1:0]     src;
  logic [SRC_W-1:0]     winner;
  logic                 any_vld;
  logic [WORD_W-1:0]    win_word;
  logic                 half_done;
  logic                 load;
  logic                 shift_en;
  logic                 in_word;

  assign half_done = (hcnt == HC_W'(CLK_DIV - 1));

`ifdef SFRM_TX_PRIO_EN
  // Fixed priority: scan from the top down so the lowest valid index wins last.
  always_comb begin
    winner  = '0;
    any_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_vld[SRC_W'(i)]) begin
        winner  = SRC_W'(i);
        any_vld = 1'b1;
      end
    end
  end
`else
  logic [SRC_W-1:0] ptr;

  // Round-robin: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int               j;
    logic [SRC_W-1:0] jj;
    winner  = '0;
    any_vld = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      jj = SRC_W'(j);
      if (!any_vld && i_req_vld[jj]) begin
        winner  = jj;
        any_vld = 1'b1;
      end
    end
  end

  // Pointer moves just past the requester that was granted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= (winner == SRC_W'(N_REQ - 1)) ? '0 : winner + SRC_W'(1);
    end
  end
`endif

  // Pick the winning requester's word with constant slices only.
  always_comb begin
    win_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == SRC_W'(k)) begin
        win_word = i_req_data[k*WORD_W +: WORD_W];
      end
    end
  end

  // State register; reset drops the link to idle immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus load/shift strobes for the datapath.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld) begin
          load      = 1'b1;
          state_nxt = BIT_HI;
        end
      end
      BIT_HI: begin
        if (half_done) begin
          state_nxt = BIT_LO;
        end
      end
      BIT_LO: begin
        if (half_done) begin
          if (idx == '0) begin
            state_nxt = GAP;
          end else begin
            shift_en  = 1'b1;
            state_nxt = BIT_HI;
          end
        end
      end
      GAP: begin
        if (half_done && (gcnt == GC_W'(2 * GAP_BITS - 1))) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Half-period counter restarts at every half boundary and while idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hcnt <= '0;
    end else if ((state == IDLE) || half_done) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + HC_W'(1);
    end
  end

  // Gap length is counted in half-periods so it reuses the divider.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gcnt <= '0;
    end else if (state != GAP) begin
      gcnt <= '0;
    end else if (half_done) begin
      gcnt <= gcnt + GC_W'(1);
    end
  end

  // Word shifter, bit index and source index; shifting happens on the
  // BIT_LO -> BIT_HI edge so data only moves with the rising bit clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift <= '0;
      idx   <= '0;
      src   <= '0;
    end else if (load) begin
      shift <= win_word;
      idx   <= IDX_W'(WORD_W - 1);
      src   <= winner;
    end else if (shift_en) begin
      shift <= {shift[WORD_W-2:0], 1'b0};
      idx   <= idx - IDX_W'(1);
    end
  end

  // Accept strobe only in IDLE; masked while reset is applied.
  always_comb begin
    o_req_rdy = '0;
    if ((state == IDLE) && any_vld && !i_rst) begin
      o_req_rdy[winner] = 1'b1;
    end
  end

  assign in_word = (state == BIT_HI) || (state == BIT_LO);
  assign o_sclk  = (state == BIT_HI);
  assign o_sd    = in_word && shift[WORD_W-1];
  assign o_fs    = in_word && (idx == IDX_W'(WORD_W - 1));
  assign o_busy  = (state != IDLE);
  assign o_src   = src;

endmodule
`default_nettype wire
